// File: rtl/pic.sv
// ---------------------------------------------------------------------------
// pic -- 16-source programmable interrupt controller on the EVB command bus.
//
// Each source line int_pulse[i] latches into PENDING[i]. PENDING & ENABLE is
// the STATUS vector, and any STATUS bit raises mp_int. Software reaches four
// registers through the EVB bus, addressed by sub id evb_cmd_addr[3:0]:
//    0 PENDING (read, write-1-to-clear)   1 ENABLE (read/write)
//    2 STATUS  (read-only)                3 CLAIM  (read-only, lowest STATUS
//                                           index or 32'hFFFF_FFFF if none)
//    4-15 read as zero, writes ignored.
//
// Configuration macro:
//    PIC_EDGE_DETECT_EN  defined   -> PENDING[i] sets on a 0->1 transition
//                                     of int_pulse[i]
//                        undefined -> PENDING[i] sets on every clock edge
//                                     where int_pulse[i] is high
//
// Parameters:
//    DEVICE_ID        value of evb_cmd_addr[15:4] that selects this block
//
// Ports:
//    clk              single clock, rising edge
//    rst              synchronous, active-high reset
//    int_pulse[15:0]  interrupt source lines, bit i is source i
//    mp_int           interrupt request to the processor
//    evb_cmd_request  bus request, held by the master until finish
//    evb_cmd_addr     [15:4] device id, [3:0] register select
//    evb_cmd_wr_mask  byte write enables, 4'b0000 means read
//    evb_cmd_wr_data  write data
//    evb_cmd_finish   one-cycle completion pulse
//    evb_cmd_rd_data  read data, valid with finish and held until next read
// ---------------------------------------------------------------------------
module pic #(
   parameter logic [11:0] DEVICE_ID = 12'h001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] int_pulse,
   output logic        mp_int,
   input  logic        evb_cmd_request,
   input  logic [15:0] evb_cmd_addr,
   input  logic [3:0]  evb_cmd_wr_mask,
   input  logic [31:0] evb_cmd_wr_data,
   output logic        evb_cmd_finish,
   output logic [31:0] evb_cmd_rd_data
);

   // Register select values carried in evb_cmd_addr[3:0].
   typedef enum logic [3:0] {
      SUB_PENDING = 4'd0,
      SUB_ENABLE  = 4'd1,
      SUB_STATUS  = 4'd2,
      SUB_CLAIM   = 4'd3
   } sub_id_e;

   localparam logic [31:0] CLAIM_NONE = 32'hFFFF_FFFF;

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [15:0] pending;
   logic [15:0] enable;

   // -----------------------------------------------------------------------
   // Combinational signals
   // -----------------------------------------------------------------------
   logic        dev_match;
   logic        accept;
   logic        is_write;
   logic [3:0]  sub_id;
   logic [15:0] lane_mask;      // per-bit write enable for the stored lanes 0-1
   logic [15:0] src_set;        // sources that set PENDING on this edge
   logic [15:0] w1c_clear;      // PENDING bits cleared by a W1C on this edge
   logic [15:0] pending_next;
   logic [15:0] enable_next;
   logic [15:0] status;
   logic        claim_found;
   logic [3:0]  claim_idx;
   logic [31:0] claim_value;
   logic [31:0] rd_mux;

   // Write data bits 31:16 map onto lanes 2-3, which have no storage.
   logic        unused_wr_hi;
   assign unused_wr_hi = ^evb_cmd_wr_data[31:16];

   // -----------------------------------------------------------------------
   // Bus decode
   // -----------------------------------------------------------------------
   // Requiring finish low makes the earliest re-acceptance two cycles after
   // the previous one, since the master's request is still high during the
   // finish cycle.
   assign dev_match = (evb_cmd_addr[15:4] == DEVICE_ID);
   assign accept    = evb_cmd_request && dev_match && !evb_cmd_finish;
   assign is_write  = |evb_cmd_wr_mask;
   assign sub_id    = evb_cmd_addr[3:0];
   assign lane_mask = {{8{evb_cmd_wr_mask[1]}}, {8{evb_cmd_wr_mask[0]}}};

   // -----------------------------------------------------------------------
   // Source condition
   // -----------------------------------------------------------------------
`ifdef PIC_EDGE_DETECT_EN
   logic [15:0] int_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         int_prev <= '0;
      end else begin
         int_prev <= int_pulse;
      end
   end

   assign src_set = int_pulse & ~int_prev;
`else
   assign src_set = int_pulse;
`endif

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w1c_clear   = '0;
      enable_next = enable;
      if (accept && is_write) begin
         case (sub_id)
            SUB_PENDING: w1c_clear   = evb_cmd_wr_data[15:0] & lane_mask;
            SUB_ENABLE:  enable_next = (enable & ~lane_mask) |
                                       (evb_cmd_wr_data[15:0] & lane_mask);
            default:     ;
         endcase
      end
   end

   // The set term is OR-ed in after the clear, so a source firing on the
   // same edge as a W1C keeps its bit set.
   assign pending_next = (pending & ~w1c_clear) | src_set;

   // -----------------------------------------------------------------------
   // Status, claim and read mux (all from the current register values, so
   // a read sees state from before any same-edge update)
   // -----------------------------------------------------------------------
   assign status = pending & enable;
   assign mp_int = |status;

   // Lowest-numbered set STATUS bit wins.
   always_comb begin
      claim_found = 1'b0;
      claim_idx   = '0;
      for (int i = 0; i < 16; i++) begin
         if (!claim_found && status[i]) begin
            claim_found = 1'b1;
            claim_idx   = i[3:0];
         end
      end
   end

   assign claim_value = claim_found ? {28'h0, claim_idx} : CLAIM_NONE;

   always_comb begin
      rd_mux = '0;
      case (sub_id)
         SUB_PENDING: rd_mux = {16'h0, pending};
         SUB_ENABLE:  rd_mux = {16'h0, enable};
         SUB_STATUS:  rd_mux = {16'h0, status};
         SUB_CLAIM:   rd_mux = claim_value;
         default:     rd_mux = '0;
      endcase
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge value of every other flop.
   // NOTE: reset is synchronous and clears every flop, including the read
   // data holding register, so nothing pending or half-accepted survives it
   // and an interrupted transaction simply never finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending         <= '0;
         enable          <= '0;
         evb_cmd_finish  <= 1'b0;
         evb_cmd_rd_data <= '0;
      end else begin
         pending        <= pending_next;
         enable         <= enable_next;
         evb_cmd_finish <= accept;
         // Read data is only captured on accepted reads; writes leave it.
         if (accept && !is_write) begin
            evb_cmd_rd_data <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_pic.sv
// ---------------------------------------------------------------------------
// tb_pic -- self-checking bench for pic.
//
// Every task starts and ends 1 time unit after a rising clock edge. Inputs
// are driven there and outputs are sampled there. Read transactions push
// their expected data into a scoreboard queue when they are issued. The
// entry is popped and compared when evb_cmd_finish is seen.
// ---------------------------------------------------------------------------
module tb_pic;

   localparam logic [11:0] DEV = 12'h001;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] int_pulse;
   logic        mp_int;
   logic        evb_cmd_request;
   logic [15:0] evb_cmd_addr;
   logic [3:0]  evb_cmd_wr_mask;
   logic [31:0] evb_cmd_wr_data;
   logic        evb_cmd_finish;
   logic [31:0] evb_cmd_rd_data;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] exp_q[$];

   pic #(.DEVICE_ID(DEV)) dut (
      .clk             (clk),
      .rst             (rst),
      .int_pulse       (int_pulse),
      .mp_int          (mp_int),
      .evb_cmd_request (evb_cmd_request),
      .evb_cmd_addr    (evb_cmd_addr),
      .evb_cmd_wr_mask (evb_cmd_wr_mask),
      .evb_cmd_wr_data (evb_cmd_wr_data),
      .evb_cmd_finish  (evb_cmd_finish),
      .evb_cmd_rd_data (evb_cmd_rd_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
      end
   endtask

   // Pop the scoreboard and compare it against the read data bus.
   task automatic pop_compare(input string name);
      logic [31:0] exp;
      vectors++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: finish with no expected read queued", name);
      end else begin
         exp = exp_q.pop_front();
         if (evb_cmd_rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_data got %h, want %h", name, evb_cmd_rd_data, exp);
         end
      end
   endtask

   // One bus transaction with optional int_pulse driven during the first
   // (accepting) edge only. Reads queue exp_rd.
   task automatic bus_pulse(input string name, input logic [3:0] sub,
                            input logic [3:0] mask, input logic [31:0] data,
                            input logic [31:0] exp_rd, input logic [15:0] pulse);
      bit got = 0;
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV, sub};
      evb_cmd_wr_mask = mask;
      evb_cmd_wr_data = data;
      int_pulse       = pulse;
      if (mask == 4'b0000) exp_q.push_back(exp_rd);
      for (int c = 0; c < 8 && !got; c++) begin
         step();
         int_pulse = '0;
         if (evb_cmd_finish === 1'b1) got = 1;
      end
      evb_cmd_request = 1'b0;
      evb_cmd_wr_mask = '0;
      vectors++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no finish within 8 cycles", name);
         if (mask == 4'b0000 && exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (mask == 4'b0000) begin
         pop_compare(name);
      end
      step();
      expect_bit({name, "_finish_width"}, evb_cmd_finish, 1'b0);
   endtask

   task automatic bus(input string name, input logic [3:0] sub, input logic [3:0] mask,
                      input logic [31:0] data, input logic [31:0] exp_rd);
      bus_pulse(name, sub, mask, data, exp_rd, 16'h0000);
   endtask

   task automatic pulse(input logic [15:0] val);
      int_pulse = val;
      step();
      int_pulse = '0;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      // Reset with a valid write request and all sources active: nothing may
      // be accepted or latched.
      rst             = 1'b1;
      int_pulse       = 16'hFFFF;
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV, 4'd1};
      evb_cmd_wr_mask = 4'b0011;
      evb_cmd_wr_data = 32'h0000_FFFF;
      for (int c = 0; c < 3; c++) begin
         step();
         expect_bit("reset_finish", evb_cmd_finish, 1'b0);
      end
      rst             = 1'b0;
      int_pulse       = '0;
      evb_cmd_request = 1'b0;
      evb_cmd_wr_mask = '0;
      step();
      expect_bit("reset_mp_int", mp_int, 1'b0);
      vectors++;
      if (evb_cmd_rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd_data: got %h, want 00000000", evb_cmd_rd_data);
      end
      bus("reset_pending", 4'd0, 4'b0000, '0, 32'h0000_0000);
      bus("reset_enable",  4'd1, 4'b0000, '0, 32'h0000_0000);
   endtask

   task automatic test_enable_int();
      bus("en_write", 4'd1, 4'b0011, 32'h0000_0001, '0);
      expect_bit("en_mp_int_before", mp_int, 1'b0);
      pulse(16'h0001);
      expect_bit("en_mp_int_after", mp_int, 1'b1);
      bus("en_claim", 4'd3, 4'b0000, '0, 32'h0000_0000);
   endtask

   task automatic test_w1c();
      bus("w1c_write", 4'd0, 4'b0011, 32'h0000_0001, '0);
      expect_bit("w1c_mp_int", mp_int, 1'b0);
      bus("w1c_pending", 4'd0, 4'b0000, '0, 32'h0000_0000);
      bus("w1c_claim_none", 4'd3, 4'b0000, '0, 32'hFFFF_FFFF);
   endtask

   task automatic test_masked_sources();
      bus("mask_en0", 4'd1, 4'b0011, 32'h0000_0000, '0);
      pulse(16'h0088);
      expect_bit("mask_mp_int_low", mp_int, 1'b0);
      bus("mask_pending", 4'd0, 4'b0000, '0, 32'h0000_0088);
      bus("mask_status",  4'd2, 4'b0000, '0, 32'h0000_0000);
      bus("mask_en_all",  4'd1, 4'b0011, 32'h0000_FFFF, '0);
      expect_bit("mask_mp_int_high", mp_int, 1'b1);
      bus("mask_claim",   4'd3, 4'b0000, '0, 32'h0000_0003);
      bus("mask_en_again", 4'd1, 4'b0011, 32'h0000_FFFF, '0);
      vectors++;
      if (evb_cmd_rd_data !== 32'h0000_0003) begin
         errors++;
         $display("FAIL rd_hold_on_write: got %h, want 00000003", evb_cmd_rd_data);
      end
      bus("mask_unused_sub", 4'd9, 4'b0000, '0, 32'h0000_0000);
   endtask

   task automatic test_bad_id();
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV + 12'd1, 4'd1};
      evb_cmd_wr_mask = 4'b0011;
      evb_cmd_wr_data = 32'h0000_0000;
      for (int c = 0; c < 5; c++) begin
         step();
         expect_bit("bad_id_finish", evb_cmd_finish, 1'b0);
      end
      evb_cmd_request = 1'b0;
      evb_cmd_wr_mask = '0;
      step();
      bus("bad_id_enable",  4'd1, 4'b0000, '0, 32'h0000_FFFF);
      bus("bad_id_pending", 4'd0, 4'b0000, '0, 32'h0000_0088);
   endtask

   task automatic test_byte_lanes();
      bus("lane0_write", 4'd1, 4'b0001, 32'hAAAA_5512, '0);
      bus("lane0_read",  4'd1, 4'b0000, '0, 32'h0000_FF12);
      bus("lane1_write", 4'd1, 4'b0010, 32'h0000_3400, '0);
      bus("lane1_read",  4'd1, 4'b0000, '0, 32'h0000_3412);
      bus("lane23_write", 4'd1, 4'b1100, 32'hFFFF_FFFF, '0);
      bus("lane23_read",  4'd1, 4'b0000, '0, 32'h0000_3412);
      // 0x0088 & 0x3412 has no common bit.
      expect_bit("lane_mp_int", mp_int, 1'b0);
      bus("lane_claim_none", 4'd3, 4'b0000, '0, 32'hFFFF_FFFF);
   endtask

   task automatic test_set_priority();
      bus("prio_clear_all", 4'd0, 4'b0011, 32'h0000_FFFF, '0);
      bus("prio_en_all",    4'd1, 4'b0011, 32'h0000_FFFF, '0);
      bus_pulse("prio_w1c", 4'd0, 4'b0011, 32'h0000_0020, '0, 16'h0020);
      bus("prio_pending", 4'd0, 4'b0000, '0, 32'h0000_0020);
      bus("prio_claim",   4'd3, 4'b0000, '0, 32'h0000_0005);
   endtask

   task automatic test_edge_detect();
      logic [31:0] exp_pend;
`ifdef PIC_EDGE_DETECT_EN
      exp_pend = 32'h0000_0000;
`else
      exp_pend = 32'h0000_0004;
`endif
      bus("edge_clear_all", 4'd0, 4'b0011, 32'h0000_FFFF, '0);
      int_pulse = 16'h0004;
      step();                              // 1st high edge
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV, 4'd0};
      evb_cmd_wr_mask = 4'b0011;
      evb_cmd_wr_data = 32'h0000_0004;
      step();                              // 2nd high edge, W1C accepted
      expect_bit("edge_w1c_finish", evb_cmd_finish, 1'b1);
      evb_cmd_request = 1'b0;
      evb_cmd_wr_mask = '0;
      step();                              // 3rd high edge
      expect_bit("edge_finish_low", evb_cmd_finish, 1'b0);
      step();                              // 4th high edge
      int_pulse = '0;
      bus("edge_pending", 4'd0, 4'b0000, '0, exp_pend);
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_fin = 4'b0101;       // bit c = finish after edge c
      exp_q.push_back(32'h0000_FFFF);
      exp_q.push_back(32'h0000_FFFF);
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV, 4'd1};
      evb_cmd_wr_mask = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         step();
         expect_bit("b2b_finish", evb_cmd_finish, exp_fin[c]);
         if (evb_cmd_finish === 1'b1) pop_compare("b2b_read");
         if (c == 2) evb_cmd_request = 1'b0;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: %0d reads not completed, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      evb_cmd_request = 1'b1;
      evb_cmd_addr    = {DEV, 4'd1};
      evb_cmd_wr_mask = 4'b0011;
      evb_cmd_wr_data = 32'h0000_1234;
      rst             = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         expect_bit("mid_reset_finish", evb_cmd_finish, 1'b0);
      end
      rst             = 1'b0;
      evb_cmd_request = 1'b0;
      evb_cmd_wr_mask = '0;
      step();
      expect_bit("mid_reset_finish_after", evb_cmd_finish, 1'b0);
      expect_bit("mid_reset_mp_int", mp_int, 1'b0);
      bus("mid_reset_enable", 4'd1, 4'b0000, '0, 32'h0000_0000);
   endtask

   // -----------------------------------------------------------------------
   initial begin
      rst             = 1'b1;
      int_pulse       = '0;
      evb_cmd_request = 1'b0;
      evb_cmd_addr    = '0;
      evb_cmd_wr_mask = '0;
      evb_cmd_wr_data = '0;
      step();
      test_reset();
      test_enable_int();
      test_w1c();
      test_masked_sources();
      test_bad_id();
      test_byte_lanes();
      test_set_priority();
      test_edge_detect();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
